// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch queue: issues word fetches, buffers {pc, inst} pairs
// and restarts cleanly on redirect, dropping any response already in flight.
//   state     | meaning
//   S_IDLE    | no request outstanding
//   S_REQ     | request at o_mem_addr outstanding, response is pushed
//   S_DISCARD | request outstanding after a redirect, response is dropped
module if_prefetch #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] PC_RESET = '0,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   output logic                   o_mem_req,
   output logic [XLEN-1:0]        o_mem_addr,
   input  logic                   i_mem_ready,
   input  logic [XLEN-1:0]        i_mem_data,
   input  logic                   i_redirect,
   input  logic [XLEN-1:0]        i_redirect_pc,
   output logic                   o_valid,
   output logic [XLEN-1:0]        o_inst,
   output logic [XLEN-1:0]        o_pc,
   input  logic                   i_ready,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned    AW      = $clog2(DEPTH);
   localparam int unsigned    CW      = AW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   req_addr_q, req_addr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [XLEN-1:0]   inst_q [DEPTH];
   logic [XLEN-1:0]   pc_q   [DEPTH];

   logic              push;
   logic              pop;
   logic [CW-1:0]     count_after_push;
   logic [XLEN-1:0]   redirect_pc;
   logic [XLEN-1:0]   fetch_pc_inc;

   assign redirect_pc      = i_redirect_pc & ~XLEN'(3);
   assign fetch_pc_inc     = fetch_pc_q + XLEN'(4);
   assign pop              = (count_q != '0) && i_ready && !i_redirect;
   assign count_after_push = count_q + CW'(1) - CW'(pop);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      push       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_redirect) begin
               fetch_pc_d = redirect_pc;
               req_addr_d = redirect_pc;
               state_d    = S_REQ;
            end else if (count_q < DEPTH_C) begin
               req_addr_d = fetch_pc_q;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (i_redirect) begin
               fetch_pc_d = redirect_pc;
               if (i_mem_ready) begin
                  req_addr_d = redirect_pc;
               end else begin
                  state_d = S_DISCARD;
               end
            // A full queue holds the response until a same-cycle pop frees a slot
            end else if (i_mem_ready && ((count_q != DEPTH_C) || pop)) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_inc;
               if (count_after_push < DEPTH_C) begin
                  req_addr_d = fetch_pc_inc;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DISCARD: begin
            if (i_redirect) begin
               fetch_pc_d = redirect_pc;
            end
            if (i_mem_ready) begin
               req_addr_d = i_redirect ? redirect_pc : fetch_pc_q;
               state_d    = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (i_redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= PC_RESET;
         req_addr_q <= PC_RESET;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: nothing is read unless count_q says it was written
   always_ff @(posedge i_clk) begin
      if (push) begin
         inst_q[wr_ptr_q] <= i_mem_data;
         pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
   end

   assign o_mem_req  = (state_q != S_IDLE);
   assign o_mem_addr = req_addr_q;
   assign o_valid    = (count_q != '0);
   assign o_inst     = inst_q[rd_ptr_q];
   assign o_pc       = pc_q[rd_ptr_q];
   assign o_count    = count_q;

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter XLEN, 32, instruction and address width.
REQ-002 Parameter PC_RESET, 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter DEPTH, 4, prefetch queue entries; power of two, >= 2.
REQ-004 Clock and reset SHALL be one clock with asynchronous, active-high reset; ports i_clk and i_rst as below.
REQ-005 i_clk  in  1  clock, all state on rising edge.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 o_mem_req  out  1  fetch request to memory.
REQ-008 o_mem_addr  out  XLEN  word-aligned fetch address.
REQ-009 i_mem_ready  in  1  request accepted; i_mem_data valid this cycle.
REQ-010 i_mem_data  in  XLEN  fetched instruction word.
REQ-011 i_redirect  in  1  flush and restart fetch (branch, jump, trap, xRET).
REQ-012 i_redirect_pc  in  XLEN  new fetch address when i_redirect=1.
REQ-013 o_valid  out  1  queue head holds a valid instruction.
REQ-014 o_inst  out  XLEN  instruction at queue head.
REQ-015 o_pc  out  XLEN  PC of instruction at queue head.
REQ-016 i_ready  in  1  consumer takes head when o_valid && i_ready.
REQ-017 o_count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 FSM states: IDLE (no request), REQ (o_mem_req=1), DISCARD (o_mem_req=1, response dropped).
REQ-019 IDLE->REQ when not redirecting and (count + 0) < DEPTH; o_mem_addr = fetch_pc.
REQ-020 In REQ/DISCARD, o_mem_req and o_mem_addr SHALL stay constant until i_mem_ready=1; one request outstanding max.
REQ-021 REQ with i_mem_ready=1 and no redirect: push {fetch_pc, i_mem_data}, fetch_pc += 4; stay REQ if count after push/pop < DEPTH, else IDLE.
REQ-022 Push SHALL occur only if a slot is free after the same-cycle pop; issue is gated so push never overflows.
REQ-023 Fill latency: with i_mem_ready=1 in the request cycle, o_valid SHALL rise on the next clock edge.
REQ-024 Pop: o_valid && i_ready removes head; simultaneous push and pop leaves count unchanged.
REQ-025 Full (count==DEPTH): no new request issued; pending request completes only if a pop frees a slot that cycle, else held.
REQ-026 Empty: o_valid=0; o_inst/o_pc hold last head value (don't-care to consumer).
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; count saturates neither way (overflow/underflow forbidden by design).
REQ-028 i_redirect: queue flushed (count=0, o_valid=0 next cycle), fetch_pc=i_redirect_pc, same-cycle pop and push ignored.
REQ-029 Redirect in REQ without i_mem_ready: go DISCARD, hold old address until i_mem_ready, drop data, then REQ at new fetch_pc.
REQ-030 Redirect in REQ with i_mem_ready=1 same cycle: data dropped, next state REQ at i_redirect_pc.
REQ-031 Redirect in DISCARD: update fetch_pc only; remain DISCARD until ready.
REQ-032 Redirect in IDLE: next state REQ at i_redirect_pc.
REQ-033 fetch_pc increments modulo 2^XLEN (wraps 32'hFFFF_FFFC -> 0).
REQ-034 i_redirect_pc[1:0] SHALL be forced to 0 when loaded.

Reset
REQ-035 On i_rst=1, immediately: state IDLE, fetch_pc=PC_RESET, pointers 0, count 0, o_valid=0, o_mem_req=0, o_count=0.
REQ-036 Reset mid-request abandons it; memory sees o_mem_req drop asynchronously.
REQ-037 First request SHALL issue on the first edge after i_rst deasserts.

Verification
REQ-038 Reset release, i_mem_ready always 1, i_ready=0 -> requests at 0x0,0x4,0x8,0xC; o_count reaches 4; o_mem_req=0 after; o_pc=0x0.
REQ-039 Steady stream, i_ready=1, i_mem_ready=1 -> one instruction per cycle, o_pc increments by 4, o_count stays 1.
REQ-040 Redirect to 0x100 while REQ stalled (i_mem_ready=0 three cycles) -> o_mem_addr held at old value, returned word dropped, next request addr 0x100, first o_pc=0x100.
REQ-041 Queue full (4) with request pending, pop in same cycle as i_mem_ready -> count stays 4, order preserved.
REQ-042 PC_RESET=32'hFFFF_FFF8, DEPTH=2 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0 after pop.
REQ-043 i_rst asserted mid-request -> o_mem_req=0, o_valid=0 before next edge; restart at PC_RESET.
